// File: rtl/rs232_tx_arbiter.sv
// Arbiter sharing one 16-bit RS232 serializer between N_REQ requesters plus
// an on-demand link-sync word, with round-robin fairness and an acknowledge timeout.
module rs232_tx_arbiter #(
    parameter int          N_REQ     = 4,
    parameter logic [15:0] SYNC_WORD = 16'hAAAA,
    parameter int          TIMEOUT   = 16
) (
    input  logic                  clk_ref,
    input  logic                  rst,
    input  logic [16*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic                  sync_req_i,
    input  logic                  link_up_i,
    output logic [15:0]           tx_data_o,
    output logic                  tx_dv_o,
    input  logic                  tx_busy_i,
    output logic [N_REQ-1:0]      grant_o,
    output logic                  sync_sent_o,
    output logic                  timeout_o,
    output logic                  idle_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state, state_n;
    logic            sync_pend;
    logic [IW-1:0]   rr_last;
    logic [CW-1:0]   cnt, cnt_n;

    logic            issue_sync, issue_data, found, timeout_n;
    logic [IW-1:0]   pick, cand;
    logic [N_REQ-1:0] grant_n;
    int              scan;

    // Round-robin scan starting just after the last served requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        scan  = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            scan = int'(rr_last) + i;
            if (scan >= N_REQ) scan = scan - N_REQ;
            cand = IW'(scan);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        issue_sync = 1'b0;
        issue_data = 1'b0;
        timeout_n  = 1'b0;
        grant_n    = grant_o;
        case (state)
            IDLE: begin
                if (!tx_busy_i) begin
                    if (sync_pend) begin
                        issue_sync = 1'b1;
                    end else if (link_up_i && found) begin
                        issue_data = 1'b1;
                    end
                end
                if (issue_sync) begin
                    grant_n = '0;
                    state_n = WAIT_BUSY;
                end else if (issue_data) begin
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    state_n       = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                cnt_n = cnt + 1'b1;
                if (tx_busy_i) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    // Word is dropped, not retried.
                    timeout_n = 1'b1;
                    grant_n   = '0;
                    state_n   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    grant_n = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state       <= IDLE;
            sync_pend   <= 1'b0;
            rr_last     <= IW'(N_REQ - 1);
            cnt         <= '0;
            tx_data_o   <= '0;
            tx_dv_o     <= 1'b0;
            req_ready_o <= '0;
            grant_o     <= '0;
            sync_sent_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_n;
            sync_pend   <= sync_req_i | (sync_pend & ~issue_sync);
            cnt         <= cnt_n;
            grant_o     <= grant_n;
            tx_dv_o     <= issue_sync | issue_data;
            sync_sent_o <= issue_sync;
            timeout_o   <= timeout_n;
            req_ready_o <= issue_data ? grant_n : '0;
            if (issue_sync) begin
                tx_data_o <= SYNC_WORD;
            end else if (issue_data) begin
                tx_data_o <= req_data_i[16*pick +: 16];
                rr_last   <= pick;
            end
        end
    end

    assign idle_o = (state == IDLE);

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Self-checking bench for rs232_tx_arbiter: requester and serializer models
// with an issue-order scoreboard.
module tb_rs232_tx_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int BUSY_LEN = 20;

    logic               clk_ref = 1'b0;
    logic               rst = 1'b1;
    logic [16*N-1:0]    req_data_i;
    logic [N-1:0]       req_valid_i;
    logic [N-1:0]       req_ready_o;
    logic               sync_req_i = 1'b0;
    logic               link_up_i = 1'b0;
    logic [15:0]        tx_data_o;
    logic               tx_dv_o;
    logic               tx_busy_i;
    logic [N-1:0]       grant_o;
    logic               sync_sent_o;
    logic               timeout_o;
    logic               idle_o;

    typedef struct packed {
        logic [15:0]  data;
        logic [N-1:0] grant;
        logic         sync;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sent[N];
    int   cnt[N];
    logic ser_en = 1'b1;
    int   busy_cnt = 0;

    always #5 clk_ref = ~clk_ref;

    rs232_tx_arbiter #(.N_REQ(N), .SYNC_WORD(16'hAAAA), .TIMEOUT(TIMEOUT)) dut (
        .clk_ref     (clk_ref),
        .rst         (rst),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .sync_req_i  (sync_req_i),
        .link_up_i   (link_up_i),
        .tx_data_o   (tx_data_o),
        .tx_dv_o     (tx_dv_o),
        .tx_busy_i   (tx_busy_i),
        .grant_o     (grant_o),
        .sync_sent_o (sync_sent_o),
        .timeout_o   (timeout_o),
        .idle_o      (idle_o)
    );

    // Requester k holds word {k+1, seq} while it still has words queued.
    for (genvar k = 0; k < N; k++) begin : g_req
        assign req_valid_i[k]         = (sent[k] < cnt[k]);
        assign req_data_i[16*k +: 16] = {4'(k + 1), 12'(sent[k])};
    end

    // Serializer: busy for BUSY_LEN cycles after each dv when enabled.
    always @(posedge clk_ref) begin
        if (tx_dv_o && ser_en) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy_i = (busy_cnt != 0);

    // Scoreboard: every issue must match the next expected word.
    always @(negedge clk_ref) begin
        exp_t e;
        if (tx_dv_o === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_dv: got data=%h grant=%b sync=%b, required no issue",
                         tx_data_o, grant_o, sync_sent_o);
            end else begin
                e = sb.pop_front();
                if ({tx_data_o, grant_o, sync_sent_o} !== {e.data, e.grant, e.sync}) begin
                    n_fail++;
                    $display("FAIL issue_word: got data=%h grant=%b sync=%b, required data=%h grant=%b sync=%b",
                             tx_data_o, grant_o, sync_sent_o, e.data, e.grant, e.sync);
                end
                n_checks++;
                if (req_ready_o !== e.grant) begin
                    n_fail++;
                    $display("FAIL ready_with_dv: got %b, required %b", req_ready_o, e.grant);
                end
            end
        end else begin
            n_checks++;
            if (req_ready_o !== '0 || sync_sent_o !== 1'b0) begin
                n_fail++;
                $display("FAIL pulse_without_dv: got ready=%b sync_sent=%b, required 0/0",
                         req_ready_o, sync_sent_o);
            end
        end
        for (int k = 0; k < N; k++) if (req_ready_o[k] === 1'b1) sent[k]++;
    end

    task automatic wait_drain(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_ref);
            if (sb.size() == 0 && idle_o === 1'b1 && !tx_busy_i) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_dv(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_ref);
            if (tx_dv_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_data(input int k, input int seq);
        sb.push_back('{data: {4'(k + 1), 12'(seq)}, grant: N'(1 << k), sync: 1'b0});
    endtask

    task automatic push_sync();
        sb.push_back('{data: 16'hAAAA, grant: '0, sync: 1'b1});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_ref);
        n_checks++;
        if ({tx_dv_o, req_ready_o, grant_o, sync_sent_o, timeout_o, tx_data_o, idle_o} !==
            {1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got dv=%b rdy=%b gnt=%b ss=%b to=%b data=%h idle=%b, required zeros idle=1",
                     tx_dv_o, req_ready_o, grant_o, sync_sent_o, timeout_o, tx_data_o, idle_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_sync_priority();
        bit ok;
        int s0;
        link_up_i = 1'b0;
        s0 = sent[0];
        cnt[0] = sent[0] + 1;
        sync_req_i = 1'b1;
        push_sync();
        @(negedge clk_ref);
        sync_req_i = 1'b0;
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL sync_drain: got timeout, required sync issued"); end
        repeat (40) @(negedge clk_ref);
        n_checks++;
        if (sent[0] != s0) begin
            n_fail++;
            $display("FAIL link_down_gate: got %0d grants to req0, required 0", sent[0] - s0);
        end
        link_up_i = 1'b1;
        push_data(0, sent[0]);
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL link_up_grant: got timeout, required req0 word"); end
    endtask

    task automatic test_round_robin();
        bit ok;
        rst = 1'b1;
        @(negedge clk_ref);
        rst = 1'b0;
        push_data(0, sent[0]);
        push_data(1, sent[1]);
        push_data(2, sent[2]);
        push_data(3, sent[3]);
        push_data(0, sent[0] + 1);
        cnt[0] = sent[0] + 2;
        for (int k = 1; k < N; k++) cnt[k] = sent[k] + 1;
        wait_drain(400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_drain: got %0d words left, required 0", sb.size()); end
    endtask

    task automatic test_wrap_skip();
        bit ok;
        push_data(2, sent[2]);
        cnt[2] = sent[2] + 1;
        wait_drain(200, ok);
        push_data(0, sent[0]);
        push_data(1, sent[1]);
        cnt[0] = sent[0] + 1;
        cnt[1] = sent[1] + 1;
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wrap_drain: got %0d words left, required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        push_sync();
        push_sync();
        push_data(3, sent[3]);
        sync_req_i = 1'b1;
        @(negedge clk_ref);
        cnt[3] = sent[3] + 1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_ref);
            if (sync_sent_o === 1'b1) begin ok = 1'b1; break; end
        end
        sync_req_i = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_first_sync: got none, required sync_sent"); end
        wait_drain(300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d words left, required 0", sb.size()); end
    endtask

    task automatic test_timeout();
        bit ok;
        int d, extra;
        ser_en = 1'b0;
        push_data(1, sent[1]);
        cnt[1] = sent[1] + 1;
        wait_dv(100, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL to_dv: got no dv, required one");
        end else begin
            d = 0;
            for (int i = 0; i < 3 * TIMEOUT; i++) begin
                @(negedge clk_ref);
                d++;
                if (timeout_o === 1'b1) break;
            end
            n_checks++;
            if (d != TIMEOUT || timeout_o !== 1'b1) begin
                n_fail++;
                $display("FAIL to_latency: got %0d cycles (to=%b), required %0d", d, timeout_o, TIMEOUT);
            end
            n_checks++;
            if (idle_o !== 1'b1 || grant_o !== '0) begin
                n_fail++;
                $display("FAIL to_idle: got idle=%b grant=%b, required 1/0", idle_o, grant_o);
            end
            @(negedge clk_ref);
            n_checks++;
            if (timeout_o !== 1'b0) begin
                n_fail++;
                $display("FAIL to_pulse_width: got %b, required 0", timeout_o);
            end
            extra = 0;
            for (int i = 0; i < 3 * TIMEOUT; i++) begin
                @(negedge clk_ref);
                if (tx_dv_o === 1'b1) extra++;
            end
            n_checks++;
            if (extra != 0) begin
                n_fail++;
                $display("FAIL to_no_retry: got %0d dv, required 0", extra);
            end
        end
        ser_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        push_data(2, sent[2]);
        cnt[2] = sent[2] + 1;
        wait_dv(100, ok);
        repeat (5) @(negedge clk_ref);
        n_checks++;
        if (grant_o !== 4'b0100 || idle_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_done: got grant=%b idle=%b, required 0100/0", grant_o, idle_o);
        end
        rst = 1'b1;
        @(negedge clk_ref);
        n_checks++;
        if ({tx_dv_o, req_ready_o, grant_o, sync_sent_o, timeout_o, tx_data_o, idle_o} !==
            {1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset_state: got dv=%b rdy=%b gnt=%b data=%h idle=%b, required zeros idle=1",
                     tx_dv_o, req_ready_o, grant_o, tx_data_o, idle_o);
        end
        rst = 1'b0;
        push_data(0, sent[0]);
        push_data(3, sent[3]);
        cnt[0] = sent[0] + 1;
        cnt[3] = sent[3] + 1;
        wait_drain(300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL mid_after_reset: got %0d words left, required 0", sb.size()); end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            sent[k] = 0;
            cnt[k]  = 0;
        end
        test_reset();
        test_sync_priority();
        test_round_robin();
        test_wrap_skip();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge clk_ref);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
